// File: rtl/pulse_rate_counter_pkg.sv
// Shared types and defaults for the pulse rate counter: FSM state, parameter
// defaults and a saturating increment helper.
package pulse_counter_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned GATE_W_DEF      = 16;
  localparam int unsigned DEAD_CYCLES_DEF = 4;
  localparam int unsigned DEAD_W          = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Increment val by one when inc is set, never exceeding lim.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] lim);
    if (inc && (val < lim)) return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/pulse_rate_counter_if.sv
// Result port of the pulse rate counter: a count with status flags on a
// valid/ready handshake.
interface pulse_rate_counter_if
  import pulse_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             count_ready;
  logic             saturated;
  logic             overrun;

  modport master (
    output count_out,
    output count_valid,
    output saturated,
    output overrun,
    input  count_ready
  );

  modport slave (
    input  count_out,
    input  count_valid,
    input  saturated,
    input  overrun,
    output count_ready
  );

endinterface

// File: rtl/pulse_edge_filter.sv
// Rising-edge detector for pulse_in with an optional non-paralyzable dead time
// (enabled by defining DEAD_TIME_EN).
module pulse_edge_filter
  import pulse_counter_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic edge_acc_c
);

  if ((DEAD_CYCLES < 1) || (DEAD_CYCLES > ((2 ** DEAD_W) - 1))) begin : g_bad_dead
    $error("pulse_edge_filter: DEAD_CYCLES must be 1..255");
  end

  logic pulse_q, pulse_d;
  logic edge_raw_c;

  always_comb begin
    pulse_d = pulse_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_q <= 1'b0;
    else        pulse_q <= pulse_d;
  end

  assign edge_raw_c = pulse_in & ~pulse_q;

`ifdef DEAD_TIME_EN
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);

  logic [DEAD_W-1:0] dead_q, dead_d;

  // Ignored edges do not reload the timer; it free-runs down to zero.
  always_comb begin
    edge_acc_c = edge_raw_c && (dead_q == '0);
    dead_d     = dead_q;
    if (edge_acc_c)          dead_d = DEAD_LOAD;
    else if (dead_q != '0)   dead_d = dead_q - DEAD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dead_q <= '0;
    else        dead_q <= dead_d;
  end
`else
  assign edge_acc_c = edge_raw_c;
`endif

endmodule

// File: rtl/pulse_rate_counter.sv
// Gated event scaler: counts accepted pulse edges over back-to-back windows of
// gate_len cycles and hands each result out on a valid/ready port.
// Optional dead time is enabled by defining DEAD_TIME_EN.
module pulse_rate_counter
  import pulse_counter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned GATE_W      = GATE_W_DEF,
  parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pulse_in,
  input  logic [GATE_W-1:0]  gate_len,
  output logic               busy,
  pulse_rate_counter_if.master res
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [GATE_W-1:0] gate_l_q, gate_l_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  count_out_q, count_out_d;
  logic              count_valid_q, count_valid_d;
  logic              saturated_q, saturated_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;

  logic              edge_acc_c;
  logic [CNT_W-1:0]  acc_inc_c;
  logic              sat_hit_c;
  logic              last_c;
  logic [GATE_W-1:0] gate_eff_c;

  pulse_edge_filter #(
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .edge_acc_c (edge_acc_c)
  );

  // Accumulator value including this cycle's edge, and whether it pinned at max.
  always_comb begin
    acc_inc_c  = CNT_W'(sat_inc(32'(acc_q), edge_acc_c, 32'(CNT_MAX)));
    sat_hit_c  = sat_q | (edge_acc_c && (acc_inc_c == CNT_MAX));
    last_c     = (timer_q == (gate_l_q - GATE_W'(1)));
    gate_eff_c = (gate_len == '0) ? GATE_W'(1) : gate_len;
  end

  always_comb begin
    state_d       = state_q;
    gate_l_d      = gate_l_q;
    timer_d       = timer_q;
    acc_d         = acc_q;
    sat_d         = sat_q;
    count_out_d   = count_out_q;
    count_valid_d = count_valid_q;
    saturated_d   = saturated_q;
    overrun_d     = overrun_q;

    if (count_valid_q && res.count_ready) begin
      count_valid_d = 1'b0;
      overrun_d     = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_COUNT;
          gate_l_d = gate_eff_c;
          timer_d  = '0;
          acc_d    = '0;
          sat_d    = 1'b0;
        end
      end
      ST_COUNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          timer_d = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else if (last_c) begin
          count_out_d   = acc_inc_c;
          saturated_d   = sat_hit_c;
          count_valid_d = 1'b1;
          // A load over an unconsumed result marks overrun; set beats clear.
          if (count_valid_q && !res.count_ready) overrun_d = 1'b1;
          timer_d  = '0;
          acc_d    = '0;
          sat_d    = 1'b0;
          gate_l_d = gate_eff_c;
        end else begin
          timer_d = timer_q + GATE_W'(1);
          acc_d   = acc_inc_c;
          sat_d   = sat_hit_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gate_l_q      <= '0;
      timer_q       <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      saturated_q   <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gate_l_q      <= gate_l_d;
      timer_q       <= timer_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      saturated_q   <= saturated_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign res.count_out   = count_out_q;
  assign res.count_valid = count_valid_q;
  assign res.saturated   = saturated_q;
  assign res.overrun     = overrun_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_pulse_rate_counter.sv
// Self-checking bench for pulse_rate_counter (CNT_W=4 to reach saturation).
module tb_pulse_rate_counter;

  typedef struct packed {
    logic [3:0] cnt;
    logic       sat;
    logic       ovr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pulse_in;
  logic [15:0] gate_len;
  logic        busy;

  pulse_rate_counter_if #(.CNT_W(4)) res_if ();

  pulse_rate_counter #(
    .CNT_W       (4),
    .GATE_W      (16),
    .DEAD_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .pulse_in (pulse_in),
    .gate_len (gate_len),
    .busy     (busy),
    .res      (res_if)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic mon_en = 1'b0;
  int   obs_sum, inj_sum, vcnt;
  int   last_cnt;
  int   dead_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard whenever a handshake is about to complete.
  always @(negedge clk) begin
    if (mon_en && res_if.count_valid && res_if.count_ready) begin
      exp_t e;
      total++;
      vcnt++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: result count=%0d with empty scoreboard", res_if.count_out);
      end else begin
        e = exp_q.pop_front();
        if ({res_if.count_out, res_if.saturated, res_if.overrun} !== {e.cnt, e.sat, e.ovr}) begin
          bad++;
          $display("FAIL mon_result: got cnt=%0d sat=%0b ovr=%0b want cnt=%0d sat=%0b ovr=%0b",
                   res_if.count_out, res_if.saturated, res_if.overrun, e.cnt, e.sat, e.ovr);
        end
        obs_sum  += int'(res_if.count_out);
        last_cnt  = int'(res_if.count_out);
      end
    end
  end

  function automatic logic pat(input int mode, input int cyc, input int glen);
    case (mode)
      0: return (cyc > 0) && (cyc % 3 == 1);
      1: return (cyc >= 5) && (cyc <= 11);
      2: return (cyc >= 1) && (cyc <= glen) && (cyc % 2 == 1);
      3: return (cyc == 0);
      4: return (cyc == 1) || (cyc == 3) || (cyc == 6) || (cyc == 11);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    rst_n              = 1'b0;
    enable             = 1'b0;
    pulse_in           = 1'b0;
    gate_len           = 16'd0;
    res_if.count_ready = 1'b0;
    mon_en             = 1'b0;
    dead_m             = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drives nwin windows of a pulse pattern, pushing each window's expected result.
  task automatic run_windows(input int glen, input int nwin, input int mode);
    int   eff, n;
    logic prev, p, acc;
    exp_t e;
    eff  = (glen == 0) ? 1 : glen;
    n    = 0;
    prev = 1'b0;
    gate_len           = 16'(glen);
    enable             = 1'b1;
    res_if.count_ready = 1'b1;
    mon_en             = 1'b1;
    for (int cyc = 0; cyc <= eff * nwin; cyc++) begin
      p        = pat(mode, cyc, eff);
      pulse_in = p;
      acc      = p && !prev;
`ifdef DEAD_TIME_EN
      if (acc && dead_m == 0) dead_m = 4;
      else begin
        acc = 1'b0;
        if (dead_m > 0) dead_m--;
      end
`endif
      if (cyc > 0 && acc) begin
        n++;
        inj_sum++;
      end
      if (cyc > 0 && (cyc % eff) == 0) begin
        e.cnt = 4'((n > 15) ? 15 : n);
        e.sat = (n >= 15);
        e.ovr = 1'b0;
        exp_q.push_back(e);
        n = 0;
      end
      prev = p;
      tick();
    end
    enable   = 1'b0;
    pulse_in = 1'b0;
    tick();
    tick();
    mon_en = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d results still expected, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (res_if.count_out !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", res_if.count_out); end
    total++; if (res_if.count_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", res_if.count_valid); end
    total++; if (res_if.saturated !== 1'b0) begin bad++; $display("FAIL rst_sat: got %0b want 0", res_if.saturated); end
    total++; if (res_if.overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr: got %0b want 0", res_if.overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
  endtask

  task automatic test_rate();
    do_reset();
    obs_sum = 0; inj_sum = 0; vcnt = 0;
    run_windows(10, 10, 0);
    total++;
    if (obs_sum !== inj_sum) begin
      bad++; $display("FAIL rate_sum: got %0d want %0d", obs_sum, inj_sum);
    end
    total++;
    if (vcnt !== 10) begin
      bad++; $display("FAIL rate_valid_cycles: got %0d want 10", vcnt);
    end
  endtask

  task automatic test_held();
    do_reset();
    run_windows(20, 1, 1);
    do_reset();
    run_windows(0, 4, 3);
  endtask

  task automatic test_saturation();
    do_reset();
    run_windows(40, 2, 2);
  endtask

  task automatic test_overrun();
    do_reset();
    gate_len = 16'd5;
    enable   = 1'b1;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      pulse_in           = (cyc == 2) || (cyc == 8) || (cyc == 18);
      res_if.count_ready = (cyc == 11) || (cyc == 20);
      tick();
      if (cyc == 9) begin
        total++;
        if ({res_if.count_valid, res_if.count_out, res_if.overrun} !== {1'b1, 4'd1, 1'b0}) begin
          bad++; $display("FAIL ovr_first: got v=%0b c=%0d o=%0b want v=1 c=1 o=0",
                          res_if.count_valid, res_if.count_out, res_if.overrun);
        end
      end
      if (cyc == 10) begin
        total++;
        if ({res_if.count_valid, res_if.count_out, res_if.overrun} !== {1'b1, 4'd1, 1'b1}) begin
          bad++; $display("FAIL ovr_set: got v=%0b c=%0d o=%0b want v=1 c=1 o=1",
                          res_if.count_valid, res_if.count_out, res_if.overrun);
        end
      end
      if (cyc == 11) begin
        total++;
        if ({res_if.count_valid, res_if.overrun} !== 2'b00) begin
          bad++; $display("FAIL ovr_clear: got v=%0b o=%0b want v=0 o=0", res_if.count_valid, res_if.overrun);
        end
      end
      if (cyc == 15) begin
        total++;
        if ({res_if.count_valid, res_if.count_out, res_if.overrun} !== {1'b1, 4'd0, 1'b0}) begin
          bad++; $display("FAIL ovr_w3: got v=%0b c=%0d o=%0b want v=1 c=0 o=0",
                          res_if.count_valid, res_if.count_out, res_if.overrun);
        end
      end
      if (cyc == 20) begin
        total++;
        if ({res_if.count_valid, res_if.count_out, res_if.overrun} !== {1'b1, 4'd1, 1'b0}) begin
          bad++; $display("FAIL ovr_ready_on_load: got v=%0b c=%0d o=%0b want v=1 c=1 o=0",
                          res_if.count_valid, res_if.count_out, res_if.overrun);
        end
      end
    end
    enable = 1'b0; pulse_in = 1'b0; res_if.count_ready = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    gate_len = 16'd10;
    for (int cyc = 0; cyc <= 22; cyc++) begin
      enable   = (cyc < 15);
      pulse_in = (cyc == 3) || (cyc == 9) || (cyc == 18);
      tick();
      if (cyc == 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_on: got %0b want 1", busy); end
      end
      if (cyc == 15) begin
        total++;
        if ({busy, res_if.count_valid, res_if.count_out} !== {1'b0, 1'b1, 4'd2}) begin
          bad++; $display("FAIL abort_drop: got busy=%0b v=%0b c=%0d want busy=0 v=1 c=2",
                          busy, res_if.count_valid, res_if.count_out);
        end
      end
    end
    total++;
    if ({res_if.count_valid, res_if.count_out, res_if.overrun} !== {1'b1, 4'd2, 1'b0}) begin
      bad++; $display("FAIL abort_no_result: got v=%0b c=%0d o=%0b want v=1 c=2 o=0",
                      res_if.count_valid, res_if.count_out, res_if.overrun);
    end
    enable = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      pulse_in = cyc[0];
      tick();
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({res_if.count_out, res_if.count_valid, res_if.saturated, res_if.overrun, busy} !== 8'd0) begin
      bad++; $display("FAIL async_reset: got c=%0d v=%0b s=%0b o=%0b busy=%0b want all 0",
                      res_if.count_out, res_if.count_valid, res_if.saturated, res_if.overrun, busy);
    end
    rst_n = 1'b1;
    enable = 1'b0; pulse_in = 1'b0;
  endtask

  task automatic test_dead_time();
    int want;
`ifdef DEAD_TIME_EN
    want = 3;
`else
    want = 4;
`endif
    do_reset();
    last_cnt = -1;
    run_windows(20, 1, 4);
    total++;
    if (last_cnt !== want) begin
      bad++; $display("FAIL dead_time_count: got %0d want %0d", last_cnt, want);
    end
  endtask

  initial begin
    test_reset();
    test_rate();
    test_held();
    test_saturation();
    test_overrun();
    test_abort();
    test_dead_time();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
